// File: rtl/stopwatch_button_ctrl_if.sv
// Button-side signal bundle for the stopwatch start/stop button conditioner.
interface stopwatch_button_ctrl_if;
   logic btn_raw;
   logic toggle;
   logic clear;
   logic btn_state;

   // Stimulus side: drives the raw button, observes the conditioned outputs.
   modport master (
      output btn_raw,
      input  toggle,
      input  clear,
      input  btn_state
   );

   // Conditioner side: consumes the raw button, produces the control pulses.
   modport slave (
      input  btn_raw,
      output toggle,
      output clear,
      output btn_state
   );
endinterface

// File: rtl/stopwatch_button_ctrl.sv
// Synchronises, debounces and classifies the stopwatch start/stop button into
// one-cycle toggle (short press) and clear (long press) pulses.
module stopwatch_button_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned LONG_CYCLES     = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   stopwatch_button_ctrl_if.slave bus
);

   localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned HOLD_W = $clog2(LONG_CYCLES);

   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HELD = 2'd1,
      LONG = 2'd2
   } state_t;

   logic              s1;
   logic              s2;
   logic              btn_state;
   logic [DB_W-1:0]   db_cnt;

   state_t            state;
   state_t            state_nxt;
   logic [HOLD_W-1:0] hold_cnt;
   logic [HOLD_W-1:0] hold_nxt;
   logic              toggle;
   logic              toggle_nxt;
   logic              clear;
   logic              clear_nxt;

   // Two-flop synchroniser; the only consumer of the asynchronous button.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= bus.btn_raw;
         s2 <= s1;
      end
   end

   // Debouncer: flip the level only after DEBOUNCE_CYCLES consecutive disagreements.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         btn_state <= 1'b0;
         db_cnt    <= '0;
      end else if (s2 == btn_state) begin
         db_cnt    <= '0;
      end else if (db_cnt == DB_LAST) begin
         btn_state <= s2;
         db_cnt    <= '0;
      end else begin
         db_cnt    <= db_cnt + DB_W'(1);
      end
   end

   // Press FSM state, hold counter and pulse registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         hold_cnt <= '0;
         toggle   <= 1'b0;
         clear    <= 1'b0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_nxt;
         toggle   <= toggle_nxt;
         clear    <= clear_nxt;
      end
   end

   // Press classification; a release in HELD wins over the long threshold.
   always_comb begin
      state_nxt  = state;
      hold_nxt   = hold_cnt;
      toggle_nxt = 1'b0;
      clear_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (btn_state) begin
               state_nxt = HELD;
               hold_nxt  = '0;
            end
         end
         HELD: begin
            if (!btn_state) begin
               state_nxt  = IDLE;
               toggle_nxt = 1'b1;
            end else if (hold_cnt == HOLD_LAST) begin
               state_nxt = LONG;
               clear_nxt = 1'b1;
            end else begin
               hold_nxt = hold_cnt + HOLD_W'(1);
            end
         end
         LONG: begin
            if (!btn_state) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign bus.toggle    = toggle;
   assign bus.clear     = clear;
   assign bus.btn_state = btn_state;

endmodule
